systolic_seq_ctrl: RTL and testbench
====================================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for the 4x4 output-stationary systolic array. On en it clears the PE accumulators.
//  It then fetches A columns and B rows from operand memories and applies diagonal skew per lane.
//  It waits for the array to drain, latches all N*N results into a result buffer and raises done.
//  The result buffer is read back through read_addr_C/read_data_C. It sits between the operand RAMs and the array.
// PARAMETERS
//  N          4        array dimension (rows = cols = inner dimension K)
//  DW         8        operand width per element
//  CW         16       accumulator/result width per element
//  DRAIN_CYC  3*N-1    cycles waited after last fetch before results are stable (11 for N=4)
// PORTS
//  clk          in   1        single clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  en           in   1        start request; level-sampled in IDLE
//  done         out  1        high in DONE state; held until en deasserts
//  addr_AB      out  $clog2(N) fetch index k: column k of A and row k of B (same address to both RAMs)
//  rd_en_AB     out  1        read strobe to A/B RAMs; data returns 1 cycle later
//  rd_data_A    in   N*DW     A[0..N-1][k]; lane i = bits [i*DW +: DW]
//  rd_data_B    in   N*DW     B[k][0..N-1]; lane j = bits [j*DW +: DW]
//  arr_clear    out  1        one-cycle accumulator clear to all PEs
//  a_feed       out  N*DW     skewed row inputs to array west edge
//  a_vld        out  N        per-row valid
//  b_feed       out  N*DW     skewed column inputs to array north edge
//  b_vld        out  N        per-column valid
//  c_in         in   N*N*CW   PE accumulators, element (r,c) at index r*N+c
//  read_addr_C  in   5        result buffer read address
//  read_data_C  out  CW       combinational read of buffer[read_addr_C]; 0 when read_addr_C >= N*N
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; done=0, rd_en_AB=0, addr_AB=0, arr_clear=0.
//   - all a_/b_ feed and vld regs = 0; skew pipelines flushed; result buffer = 0.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> STORE -> DONE -> IDLE.
//   - IDLE: en=1 sampled at edge E0 -> CLEAR.
//   - CLEAR (1 cycle): arr_clear=1, k<=0.
//   - FEED (N cycles, E1..E(N)): rd_en_AB=1, addr_AB=k, k++; exits at k==N-1 -> DRAIN.
//   - DRAIN (DRAIN_CYC cycles): down-counter, no fetch; exits when count reaches 0.
//   - STORE (1 cycle): buffer[r*N+c] <= c_in element (r,c), all N*N elements in a single cycle.
//   - DONE: done=1. Stays while en=1; en=0 -> IDLE with done=0 on the next cycle.
//  Latency: done first high after edge E(2+N+DRAIN_CYC) = E17 for defaults.
//  Skew:
//   - RAM data is valid the cycle after rd_en_AB. Lane i of A and lane j of B are then delayed i / j extra cycles.
//   - For defaults, a_vld[0] is high for the 4 cycles after E2..E5; a_vld[3] after E5..E8. b_vld is the same.
//   - Feed data is 0 whenever the matching vld is 0 (no stale operands).
//  en deasserted during CLEAR/FEED/DRAIN/STORE is ignored; the run completes.
//  en held high through DONE does not restart; a new run requires en low for >= 1 cycle.
//  The result buffer changes only in STORE. Reads during a run return the previous run's results.
//  rst at any cycle aborts: next cycle = reset values, buffer cleared, skew flushed.
//  Arithmetic: no math in this block. Widths pass through; read_data_C is zero-extended/0 beyond N*N-1.
// STRUCTURE
//  systolic_pkg:
//   - localparams N, DW, CW, DRAIN_CYC.
//   - state enum {IDLE, CLEAR, FEED, DRAIN, STORE, DONE}.
//   - function idx(r,c)=r*N+c.
//  Sub-module skew_buffer #(N, DW):
//   - N lanes of shift registers, lane i depth i, carrying data+valid.
//   - Sync reset to 0; instantiated twice (A side and B side).
//  Top level holds FSM, k counter, drain counter, N*N x CW result buffer and read mux.
// TESTING
//  - Identity A, B[r][c]=r*4+c+1 (1..16): en at E0 -> done rises at E17; read_addr_C 0..15 returns 1..16; addr 16,17 return 0.
//  - A=B=all 2: every C entry = 16; a_vld[i]/b_vld[i] first high exactly i cycles after lane 0; feeds are 0 when vld is low.
//  - rst asserted in FEED cycle 2: next cycle done=0, a_vld=b_vld=0, state IDLE; a new run gives correct results.
//  - en dropped during DRAIN: run completes, done at E17. en held high after DONE: no second arr_clear.
//  - Back-to-back runs: run1 identity*B, run2 all-ones*all-ones (C=4). During run2, read_addr_C=5 returns 6 until STORE, then 4.
//  - rst during DONE: done low next cycle, read_data_C = 0 for all addresses.

Source files
------------

// File: rtl/systolic_seq_ctrl_pkg.sv
// systolic_pkg: shared sizes, FSM state type and result-index helper for the systolic sequencer
//   N          array dimension (rows = cols = inner dimension K)
//   DW / CW    operand / accumulator element widths
//   DRAIN_CYC  cycles between the last fetch and stable PE results
//   AW / IW    fetch-index width / result-buffer index width
package systolic_pkg;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int DRAIN_CYC = 3 * N - 1;
    localparam int AW = $clog2(N);
    localparam int IW = $clog2(N * N);
    localparam int DCW = $clog2(DRAIN_CYC + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, STORE, DONE} state_t;
    function automatic int idx(input int r, input int c);
        return r * N + c;
    endfunction
endpackage

// File: rtl/systolic_seq_ctrl_skew_buffer.sv
// skew_buffer: per-lane diagonal delay of operand data and valid, lane i delayed i cycles
//   clk, rst   clock, synchronous active-high reset (flushes every stage)
//   data       N lanes of DW-bit operands, lane i at [i*DW +: DW]
//   valid      one valid shared by all lanes of data
//   feed       skewed operands; zero whenever the lane's valid is low
//   feed_vld   per-lane skewed valid
module skew_buffer #(
    parameter int N = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*DW-1:0] data,
    input  logic          valid,
    output logic [N*DW-1:0] feed,
    output logic [N-1:0]  feed_vld
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] gated;
        // gate at the input so no stale operand ever enters a pipeline stage
        assign gated = valid ? data[i*DW +: DW] : '0;
        if (i == 0) begin : g_pass
            assign feed[DW-1:0] = gated;
            assign feed_vld[0] = valid;
        end else begin : g_pipe
            logic [DW-1:0] d_sr [i];
            logic          v_sr [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < i; j++) begin
                        d_sr[j] <= '0;
                        v_sr[j] <= 1'b0;
                    end
                end else begin
                    d_sr[0] <= gated;
                    v_sr[0] <= valid;
                    for (int j = 1; j < i; j++) begin
                        d_sr[j] <= d_sr[j-1];
                        v_sr[j] <= v_sr[j-1];
                    end
                end
            end
            assign feed[i*DW +: DW] = d_sr[i-1];
            assign feed_vld[i] = v_sr[i-1];
        end
    end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: run sequencer for the NxN output-stationary systolic array
//   clk, rst             clock, synchronous active-high reset
//   en                   start request, level-sampled in IDLE; must drop before a new run
//   done                 high in DONE until en deasserts
//   addr_AB, rd_en_AB    fetch index k and read strobe to the A/B operand RAMs (1-cycle latency)
//   rd_data_A/B          A column k / B row k returned by the RAMs
//   arr_clear            one-cycle accumulator clear to all PEs
//   a_feed/a_vld         skewed west-edge row operands and valids
//   b_feed/b_vld         skewed north-edge column operands and valids
//   c_in                 PE accumulators, element (r,c) at index r*N+c
//   read_addr_C/data_C   combinational read of the result buffer, 0 beyond N*N-1
module systolic_seq_ctrl
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              done,
    output logic [AW-1:0]     addr_AB,
    output logic              rd_en_AB,
    input  logic [N*DW-1:0]   rd_data_A,
    input  logic [N*DW-1:0]   rd_data_B,
    output logic              arr_clear,
    output logic [N*DW-1:0]   a_feed,
    output logic [N-1:0]      a_vld,
    output logic [N*DW-1:0]   b_feed,
    output logic [N-1:0]      b_vld,
    input  logic [N*N*CW-1:0] c_in,
    input  logic [4:0]        read_addr_C,
    output logic [CW-1:0]     read_data_C
);
    state_t         state;
    logic [DCW-1:0] drain_cnt;
    logic           rd_vld;
    logic [CW-1:0]  buf_c [N*N];
    // addr_AB doubles as the fetch counter k
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            rd_en_AB  <= 1'b0;
            addr_AB   <= '0;
            arr_clear <= 1'b0;
            drain_cnt <= '0;
            rd_vld    <= 1'b0;
            for (int i = 0; i < N * N; i++) buf_c[i] <= '0;
        end else begin
            rd_vld <= rd_en_AB;
            case (state)
                IDLE: if (en) begin
                    state     <= CLEAR;
                    arr_clear <= 1'b1;
                end
                CLEAR: begin
                    arr_clear <= 1'b0;
                    rd_en_AB  <= 1'b1;
                    addr_AB   <= '0;
                    state     <= FEED;
                end
                FEED: if (addr_AB == AW'(N - 1)) begin
                    rd_en_AB  <= 1'b0;
                    addr_AB   <= '0;
                    drain_cnt <= DCW'(DRAIN_CYC - 1);
                    state     <= DRAIN;
                end else begin
                    addr_AB <= addr_AB + 1'b1;
                end
                DRAIN: if (drain_cnt == '0) state <= STORE;
                       else drain_cnt <= drain_cnt - 1'b1;
                STORE: begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            buf_c[idx(r, c)] <= c_in[idx(r, c)*CW +: CW];
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: if (!en) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // RAM data arrives one cycle after the strobe, so rd_vld qualifies it for both skew buffers
    skew_buffer #(.N(N), .DW(DW)) u_skew_a (
        .clk(clk), .rst(rst), .data(rd_data_A), .valid(rd_vld), .feed(a_feed), .feed_vld(a_vld)
    );
    skew_buffer #(.N(N), .DW(DW)) u_skew_b (
        .clk(clk), .rst(rst), .data(rd_data_B), .valid(rd_vld), .feed(b_feed), .feed_vld(b_vld)
    );
    assign read_data_C = (read_addr_C < 5'(N * N)) ? buf_c[read_addr_C[IW-1:0]] : '0;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: scoreboard bench with operand RAM and output-stationary array models
module tb_systolic_seq_ctrl;
    import systolic_pkg::*;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              done;
    logic [AW-1:0]     addr_AB;
    logic              rd_en_AB;
    logic [N*DW-1:0]   rd_data_A;
    logic [N*DW-1:0]   rd_data_B;
    logic              arr_clear;
    logic [N*DW-1:0]   a_feed;
    logic [N-1:0]      a_vld;
    logic [N*DW-1:0]   b_feed;
    logic [N-1:0]      b_vld;
    logic [N*N*CW-1:0] c_in;
    logic [4:0]        read_addr_C = '0;
    logic [CW-1:0]     read_data_C;
    int n_chk = 0;
    int n_fail = 0;
    logic [CW-1:0] q[$];
    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    logic [DW-1:0] a_pe [N][N];
    logic [DW-1:0] b_pe [N][N];
    logic [CW-1:0] acc [N][N];
    logic [DW-1:0] ain, bin;
    always #5 clk = ~clk;
    systolic_seq_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .done(done), .addr_AB(addr_AB), .rd_en_AB(rd_en_AB),
        .rd_data_A(rd_data_A), .rd_data_B(rd_data_B), .arr_clear(arr_clear),
        .a_feed(a_feed), .a_vld(a_vld), .b_feed(b_feed), .b_vld(b_vld), .c_in(c_in),
        .read_addr_C(read_addr_C), .read_data_C(read_data_C)
    );
    // operand RAMs: A column k and B row k, one-cycle read latency
    always @(posedge clk)
        if (rd_en_AB)
            for (int i = 0; i < N; i++) begin
                rd_data_A[i*DW +: DW] <= ma[i][addr_AB];
                rd_data_B[i*DW +: DW] <= mb[addr_AB][i];
            end
    // array: a moves east, b moves south, each PE accumulates a*b every cycle
    always @(posedge clk)
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ain = (c == 0) ? a_feed[r*DW +: DW] : a_pe[r][c-1];
                bin = (r == 0) ? b_feed[c*DW +: DW] : b_pe[r-1][c];
                a_pe[r][c] <= ain;
                b_pe[r][c] <= bin;
                acc[r][c] <= arr_clear ? '0 : acc[r][c] + CW'(ain) * CW'(bin);
            end
    always_comb begin
        c_in = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                c_in[(r*N+c)*CW +: CW] = acc[r][c];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic load(input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = kind == 0 ? DW'(r == c) : kind == 1 ? 8'd1 : kind == 2 ? 8'd2 : DW'($urandom_range(0, 15));
                mb[r][c] = kind == 0 ? DW'(r * N + c + 1) : kind == 1 ? 8'd1 : kind == 2 ? 8'd2 : DW'($urandom_range(0, 15));
            end
    endtask
    task automatic push_expected();
        logic [CW-1:0] s;
        q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < N; k++) s += CW'(ma[r][k]) * CW'(mb[k][c]);
                q.push_back(s);
            end
    endtask
    task automatic do_run(input string tag, input int drop_at, input int abort_at,
                          input int hold, input bit keep, input int watch5);
        int n, clears, viol;
        int first_a[N], first_b[N], cnt_a[N], cnt_b[N];
        bit seen;
        for (int i = 0; i < N; i++) begin
            first_a[i] = -1; first_b[i] = -1; cnt_a[i] = 0; cnt_b[i] = 0;
        end
        push_expected();
        if (watch5 >= 0) read_addr_C = 5'd5;
        en = 1'b1; n = 0; seen = 1'b0; clears = 0; viol = 0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            clears += int'(arr_clear);
            for (int i = 0; i < N; i++) begin
                if (a_vld[i]) begin cnt_a[i]++; if (first_a[i] < 0) first_a[i] = n; end
                else if (a_feed[i*DW +: DW] != '0) viol++;
                if (b_vld[i]) begin cnt_b[i]++; if (first_b[i] < 0) first_b[i] = n; end
                else if (b_feed[i*DW +: DW] != '0) viol++;
            end
            if (watch5 >= 0 && n == 16) chk({tag, "_c5_before_store"}, 32'(read_data_C), watch5);
            if (n == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk({tag, "_rst_done"}, 32'(done), 0);
                chk({tag, "_rst_rd_en"}, 32'(rd_en_AB), 0);
                chk({tag, "_rst_addr"}, 32'(addr_AB), 0);
                chk({tag, "_rst_vld"}, 32'({a_vld, b_vld}), 0);
                chk({tag, "_rst_feed"}, 32'(|{a_feed, b_feed}), 0);
                rst = 1'b0; en = 1'b0;
                q.delete();
                return;
            end
            if (n == drop_at) en = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk({tag, "_done_edge"}, n, 17);
            end else n++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        if (watch5 >= 0 && q.size() > 5) chk({tag, "_c5_after_store"}, 32'(read_data_C), 32'(q[5]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            clears += int'(arr_clear);
            chk({tag, "_done_held"}, 32'(done), 1);
        end
        chk({tag, "_clear_pulses"}, clears, 1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_a_vld%0d_first", tag, i), first_a[i], 2 + i);
            chk($sformatf("%s_b_vld%0d_first", tag, i), first_b[i], 2 + i);
            chk($sformatf("%s_a_vld%0d_len", tag, i), cnt_a[i], N);
            chk($sformatf("%s_b_vld%0d_len", tag, i), cnt_b[i], N);
        end
        chk({tag, "_stale_feed"}, viol, 0);
        if (keep) return;
        en = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 32'(done), 0);
    endtask
    task automatic read_back(input string tag);
        chk({tag, "_sb_size"}, q.size(), N * N);
        for (int a = 0; a < N * N && q.size() > 0; a++) begin
            read_addr_C = 5'(a); #1;
            chk($sformatf("%s_c%0d", tag, a), 32'(read_data_C), 32'(q.pop_front()));
        end
        for (int a = N * N; a < N * N + 2; a++) begin
            read_addr_C = 5'(a); #1;
            chk($sformatf("%s_c%0d_oob", tag, a), 32'(read_data_C), 0);
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 32'(done), 0);
        chk("reset_rd_en", 32'(rd_en_AB), 0);
        chk("reset_addr", 32'(addr_AB), 0);
        chk("reset_clear", 32'(arr_clear), 0);
        chk("reset_vld", 32'({a_vld, b_vld}), 0);
        chk("reset_feed", 32'(|{a_feed, b_feed}), 0);
        chk("reset_c0", 32'(read_data_C), 0);
        rst = 1'b0;
        load(0); do_run("ident", -1, -1, 5, 1'b0, -1); read_back("ident");
        load(1); do_run("ones", -1, -1, 0, 1'b0, 6); read_back("ones");
        load(2); do_run("twos", -1, -1, 0, 1'b0, -1); read_back("twos");
        load(3); do_run("abort", -1, 2, 0, 1'b0, -1);
        do_run("post_abort", -1, -1, 0, 1'b0, -1); read_back("post_abort");
        load(0); do_run("drop", 8, -1, 0, 1'b0, -1); read_back("drop");
        load(2); do_run("rst_in_done", -1, -1, 0, 1'b1, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_done_done", 32'(done), 0);
        for (int a = 0; a < 32; a++) begin
            read_addr_C = 5'(a); #1;
            chk($sformatf("rst_in_done_c%0d", a), 32'(read_data_C), 0);
        end
        rst = 1'b0; en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
